// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packer_pkg
// Description : Shared width helpers for the channel packer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package packer_pkg;

  localparam int BYTE_W = 8;

  // Width needed to hold a byte count in the range 0..depth.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to hold a byte count in the range 0..nbytes.
  function automatic int bytes_w(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_compactor.sv
`default_nettype none
// ============================================================================
// Module      : byte_compactor
// Description : Squeezes the enabled bytes of one input sample into the top
//               of the output vector, highest-index enabled byte first, and
//               reports how many bytes survived the mask.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_compactor
  import packer_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic [IN_BYTES*BYTE_W-1:0]     d_i,
  input  logic [IN_BYTES-1:0]            cfg_i,
  output logic [IN_BYTES*BYTE_W-1:0]     packed_o,
  output logic [bytes_w(IN_BYTES)-1:0]   n_o
);

  localparam int NW = bytes_w(IN_BYTES);

  // Walk bytes from high index to low, dropping masked ones, packing upward.
  always_comb begin
    int cnt;
    packed_o = '0;
    cnt      = 0;
    for (int i = IN_BYTES - 1; i >= 0; i--) begin
      if (!cfg_i[i]) begin
        packed_o[(IN_BYTES-1-cnt)*BYTE_W +: BYTE_W] = d_i[i*BYTE_W +: BYTE_W];
        cnt++;
      end
    end
    n_o = NW'(cnt);
  end

endmodule
`default_nettype wire

// File: rtl/channel_packer.sv
`default_nettype none
// ============================================================================
// Module      : channel_packer
// Description : Accepts masked multi-byte samples, buffers the enabled bytes
//               in a shifting byte array and emits OUT_BYTES-wide words with
//               valid/ready handshake; flush drains a final partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_packer
  import packer_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 4,
  parameter int DEPTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic                           cfg_stb_i,
  input  logic [IN_BYTES-1:0]            cfg_i,
  input  logic                           en_i,
  input  logic                           stb_i,
  input  logic [IN_BYTES*BYTE_W-1:0]     d_i,
  input  logic                           flush_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [OUT_BYTES*BYTE_W-1:0]    q_o,
  output logic [bytes_w(OUT_BYTES)-1:0]  bytes_o,
  output logic                           last_o,
  output logic                           busy_o,
  output logic                           overflow_o,
  output logic [level_w(DEPTH)-1:0]      level_o
);

  localparam int LW = level_w(DEPTH);
  localparam int BW = bytes_w(OUT_BYTES);
  localparam int NW = bytes_w(IN_BYTES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] C_OUT_LVL = LW'(OUT_BYTES);

  // The buffer must fit a full word's worth minus one plus a whole sample.
  if (DEPTH < IN_BYTES + OUT_BYTES - 1) begin : g_depth_check
    $error("channel_packer: DEPTH too small for IN_BYTES+OUT_BYTES-1");
  end

  // Buffer entry 0 is always the oldest byte.
  logic [BYTE_W-1:0]         buf_q [DEPTH];
  logic [BYTE_W-1:0]         buf_d [DEPTH];
  logic [IN_BYTES-1:0]       cfg_q, cfg_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      busy_q, busy_d;
  logic                      ovf_q, ovf_d;

  logic [IN_BYTES*BYTE_W-1:0] comp_bytes;
  logic [NW-1:0]              comp_n;
  logic [LW-1:0]              pop_cnt;
  logic                       pop;

  byte_compactor #(
    .IN_BYTES (IN_BYTES)
  ) u_compactor (
    .d_i      (d_i),
    .cfg_i    (cfg_q),
    .packed_o (comp_bytes),
    .n_o      (comp_n)
  );

  // Output word view derived only from registered state.
  always_comb begin
    valid_o = (level_q >= C_OUT_LVL) || (busy_q && (level_q != '0));
    pop_cnt = (level_q >= C_OUT_LVL) ? C_OUT_LVL : level_q;
    pop     = valid_o && ready_i;
    bytes_o = valid_o ? BW'(pop_cnt) : '0;
    last_o  = valid_o && busy_q && (level_q <= C_OUT_LVL);
    q_o     = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      if (valid_o && (j < int'(level_q))) begin
        q_o[(OUT_BYTES-1-j)*BYTE_W +: BYTE_W] = buf_q[AW'(j)];
      end
    end
  end

  // Next-state: config load wins; otherwise pop first, then append or drop.
  always_comb begin
    int popn;
    int lap;
    int nn;
    cfg_d   = cfg_q;
    level_d = level_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    buf_d   = buf_q;
    popn    = pop ? int'(pop_cnt) : 0;
    lap     = int'(level_q) - popn;
    nn      = int'(comp_n);
    if (cfg_stb_i) begin
      cfg_d   = cfg_i;
      level_d = '0;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_d[k] = '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_d[k] = '0;
        if (k + popn < DEPTH) begin
          buf_d[k] = buf_q[AW'(k + popn)];
        end
      end
      level_d = LW'(lap);
      if (stb_i && en_i && (nn != 0)) begin
        if (!busy_q && (lap + nn <= DEPTH)) begin
          for (int m = 0; m < IN_BYTES; m++) begin
            if (m < nn) begin
              buf_d[AW'(lap + m)] = comp_bytes[(IN_BYTES-1-m)*BYTE_W +: BYTE_W];
            end
          end
          level_d = LW'(lap + nn);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (busy_q) begin
        if (pop && last_o) begin
          busy_d = 1'b0;
        end
      end else if (flush_i && (level_d != '0)) begin
        busy_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cfg_q   <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      cfg_q   <= cfg_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < DEPTH; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;
  assign level_o    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_packer
// Description : Directed vector bench for channel_packer (defaults 4/4/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_stb;
  logic [3:0]  cfg;
  logic        en;
  logic        stb;
  logic [31:0] d;
  logic        flush;
  logic        ready;
  logic        valid_o;
  logic [31:0] q_o;
  logic [2:0]  bytes_o;
  logic        last_o;
  logic        busy_o;
  logic        overflow_o;
  logic [4:0]  level_o;

  always #5 clk = ~clk;

  channel_packer #(
    .IN_BYTES  (4),
    .OUT_BYTES (4),
    .DEPTH     (16)
  ) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .cfg_stb_i  (cfg_stb),
    .cfg_i      (cfg),
    .en_i       (en),
    .stb_i      (stb),
    .d_i        (d),
    .flush_i    (flush),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .q_o        (q_o),
    .bytes_o    (bytes_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  typedef struct {
    bit          cs;
    logic [3:0]  cfg;
    bit          en;
    bit          st;
    logic [31:0] d;
    bit          fl;
    bit          rd;
    bit          ev;
    logic [31:0] eq;
    int          eb;
    bit          el;
    bit          ebusy;
    bit          eovf;
    int          elev;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input bit cs, input logic [3:0] c, input bit e, input bit st,
                     input logic [31:0] dd, input bit fl, input bit rd,
                     input bit ev, input logic [31:0] eq, input int eb,
                     input bit el, input bit ebusy, input bit eovf, input int elev);
    vec_t v;
    v.cs = cs; v.cfg = c; v.en = e; v.st = st; v.d = dd; v.fl = fl; v.rd = rd;
    v.ev = ev; v.eq = eq; v.eb = eb; v.el = el; v.ebusy = ebusy;
    v.eovf = eovf; v.elev = elev;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {20'b0, valid_o, q_o, bytes_o, last_o, busy_o, overflow_o, level_o};
  endfunction

  function automatic logic [63:0] exps(input vec_t v);
    return {20'b0, v.ev, v.eq, 3'(v.eb), v.el, v.ebusy, v.eovf, 5'(v.elev)};
  endfunction

  initial begin
    rst_n = 1'b0; cfg_stb = 1'b0; cfg = 4'h0; en = 1'b1; stb = 1'b0;
    d = 32'h0; flush = 1'b0; ready = 1'b1;

    //  cs cfg  en st d             fl rd   ev q             b  l  bz ov lvl
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h11223344, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h55667788, 0, 1,  1, 32'h11223344, 4, 0, 0, 0, 4);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  1, 32'h55667788, 4, 0, 0, 0, 4);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 4'h5, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'hAABBCCDD, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h11223344, 0, 1,  0, 32'h0,        0, 0, 0, 0, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  1, 32'hAACC1133, 4, 0, 0, 0, 4);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 4'h0, 1, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'hA0A1A2A3, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'hB0B1B2B3, 0, 0,  1, 32'hA0A1A2A3, 4, 0, 0, 0, 4);
    add(0, 4'h0, 1, 1, 32'hC0C1C2C3, 0, 0,  1, 32'hA0A1A2A3, 4, 0, 0, 0, 8);
    add(0, 4'h0, 1, 1, 32'hD0D1D2D3, 0, 0,  1, 32'hA0A1A2A3, 4, 0, 0, 0, 12);
    add(0, 4'h0, 1, 1, 32'hE0E1E2E3, 0, 1,  1, 32'hA0A1A2A3, 4, 0, 0, 0, 16);
    add(0, 4'h0, 1, 1, 32'hF0F1F2F3, 0, 0,  1, 32'hB0B1B2B3, 4, 0, 0, 0, 16);
    add(0, 4'h0, 1, 0, 32'h0,        0, 0,  1, 32'hB0B1B2B3, 4, 0, 0, 1, 16);
    add(1, 4'h3, 1, 0, 32'h0,        0, 1,  1, 32'hB0B1B2B3, 4, 0, 0, 1, 16);
    add(0, 4'h0, 1, 1, 32'hAABBCCDD, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        1, 1,  0, 32'h0,        0, 0, 0, 0, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 0,  1, 32'hAABB0000, 2, 1, 1, 0, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  1, 32'hAABB0000, 2, 1, 1, 0, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h12345678, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        1, 1,  0, 32'h0,        0, 0, 0, 0, 2);
    add(0, 4'h0, 1, 1, 32'h9ABCDEF0, 0, 0,  1, 32'h12340000, 2, 1, 1, 0, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 0,  1, 32'h12340000, 2, 1, 1, 1, 2);
    add(1, 4'h0, 1, 0, 32'h0,        0, 0,  1, 32'h12340000, 2, 1, 1, 1, 2);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        1, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 4'hF, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'hDEADBEEF, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(1, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 0, 1, 32'hCAFEF00D, 0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h01020304, 0, 0,  0, 32'h0,        0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 32'h05060708, 0, 0,  1, 32'h01020304, 4, 0, 0, 0, 4);
    add(0, 4'h0, 1, 0, 32'h0,        1, 0,  1, 32'h01020304, 4, 0, 0, 0, 8);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  1, 32'h01020304, 4, 0, 1, 0, 8);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  1, 32'h05060708, 4, 1, 1, 0, 4);
    add(0, 4'h0, 1, 0, 32'h0,        0, 1,  0, 32'h0,        0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      cfg_stb = vq[i].cs; cfg = vq[i].cfg; en = vq[i].en; stb = vq[i].st;
      d = vq[i].d; flush = vq[i].fl; ready = vq[i].rd;
      #1;
      chk($sformatf("vec%0d", i), outs(), exps(vq[i]));
    end

    // Reset in the middle of backpressure with two words buffered.
    @(negedge clk);
    cfg_stb = 1'b0; flush = 1'b0; en = 1'b1; ready = 1'b0;
    stb = 1'b1; d = 32'h01234567;
    @(negedge clk);
    d = 32'h89ABCDEF;
    @(negedge clk);
    stb = 1'b0;
    #1;
    chk("bp_level8", {59'b0, level_o}, 64'd8);
    chk("bp_q_head", {32'b0, q_o}, 64'h01234567);
    #2 rst_n = 1'b0;
    #1;
    chk("bp_rst_async", outs(), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("bp_post_rst", outs(), 64'h0);
    end

    // Reset in the middle of a flush.
    @(negedge clk);
    stb = 1'b1; d = 32'h0A0B0C0D; ready = 1'b0;
    @(negedge clk);
    stb = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_busy", {63'b0, busy_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("fl_rst_async", outs(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("fl_post_rst", outs(), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
